// File: rtl/cl_adder4_pkg.sv
// Shared width, word and generate/propagate types for the cl_adder4 carry-lookahead slice.
package cl_adder4_pkg;

  localparam int CLA_W = 4;

  typedef logic [CLA_W-1:0] cla_word_t;

  typedef struct packed {
    cla_word_t g;
    cla_word_t p;
  } cla_pg_t;

  // Per-bit generate and propagate terms of two operands
  function automatic cla_pg_t cla_make_pg(input cla_word_t a, input cla_word_t b);
    cla_pg_t r;
    r.g = a & b;
    r.p = a ^ b;
    return r;
  endfunction

endpackage

// File: rtl/cla_carry_unit.sv
// Two-level lookahead carry network: every carry is a flat sum of products of g, p and cin.
module cla_carry_unit
  import cl_adder4_pkg::*;
(
  input  logic [CLA_W-1:0] g,
  input  logic [CLA_W-1:0] p,
  input  logic             cin,
  output logic [CLA_W:0]   c,
  output logic             grp_p,
  output logic             grp_g
);

  // Flat carry equations, no carry feeds another carry
  always_comb begin
    c[0]  = cin;
    c[1]  = g[0] | (p[0] & cin);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & cin);
    grp_p = &p;
    // Group generate is the carry-out with cin forced low
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/cl_adder4.sv
// Registered 4-bit carry-lookahead adder slice, {Cout,S} = A+B+Cin one cycle later.
// Optional group PG/GG outputs are built when CL_ADDER4_GROUP_PG_EN is defined.
module cl_adder4
  import cl_adder4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CLA_W-1:0] A,
  input  logic [CLA_W-1:0] B,
  input  logic             Cin,
  output logic             Cout,
  output logic [CLA_W-1:0] S
`ifdef CL_ADDER4_GROUP_PG_EN
  ,
  output logic             PG,
  output logic             GG
`endif
);

  cla_pg_t          pg_s;
  logic [CLA_W:0]   c_s;
  logic             grp_p_s;
  logic             grp_g_s;
  cla_word_t        sum_s;
  cla_word_t        s_r;
  logic             cout_r;

  assign pg_s = cla_make_pg(A, B);

  cla_carry_unit u_carry (
    .g     (pg_s.g),
    .p     (pg_s.p),
    .cin   (Cin),
    .c     (c_s),
    .grp_p (grp_p_s),
    .grp_g (grp_g_s)
  );

  assign sum_s = pg_s.p ^ c_s[CLA_W-1:0];

  // Sum and carry-out registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r    <= 4'h0;
      cout_r <= 1'b0;
    end else begin
      s_r    <= sum_s;
      cout_r <= c_s[CLA_W];
    end
  end

  assign S    = s_r;
  assign Cout = cout_r;

`ifdef CL_ADDER4_GROUP_PG_EN
  logic pg_r;
  logic gg_r;

  // Group propagate/generate registers for cross-slice lookahead
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pg_r <= 1'b0;
      gg_r <= 1'b0;
    end else begin
      pg_r <= grp_p_s;
      gg_r <= grp_g_s;
    end
  end

  assign PG = pg_r;
  assign GG = gg_r;
`else
  logic group_unused_s;
  assign group_unused_s = grp_p_s ^ grp_g_s;
`endif

endmodule

// File: tb/tb_cl_adder4.sv
// Table-driven self-checking bench for cl_adder4 (honours CL_ADDER4_GROUP_PG_EN).
module tb_cl_adder4;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic       Cout;
  logic [3:0] S;
`ifdef CL_ADDER4_GROUP_PG_EN
  logic       PG;
  logic       GG;
`endif

  int checks;
  int errors;

  cl_adder4 dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Cout (Cout),
    .S    (S)
`ifdef CL_ADDER4_GROUP_PG_EN
    ,
    .PG   (PG),
    .GG   (GG)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
    A = a;
    B = b;
    Cin = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] model;
  logic       lo_cout;
  logic [3:0] lo_s;
  logic [8:0] cas_exp;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    vecs[1] = '{4'h1, 4'h1, 1'b0, 4'h2, 1'b0};
    vecs[2] = '{4'h3, 4'h1, 1'b0, 4'h4, 1'b0};
    vecs[3] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0};
    vecs[4] = '{4'h7, 4'h7, 1'b0, 4'hE, 1'b0};
    vecs[5] = '{4'h4, 4'hC, 1'b0, 4'h0, 1'b1};
    vecs[6] = '{4'h4, 4'hD, 1'b0, 4'h1, 1'b1};
    vecs[7] = '{4'h6, 4'hD, 1'b0, 4'h3, 1'b1};
    vecs[8] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
    vecs[9] = '{4'h9, 4'h6, 1'b1, 4'h0, 1'b1};

    // Reset takes effect without a clock edge
    rst = 1'b0;
    drive(4'hF, 4'hF, 1'b1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_s", {28'd0, S}, 32'h0);
    chk("rst_async_cout", {31'd0, Cout}, 32'h0);
`ifdef CL_ADDER4_GROUP_PG_EN
    chk("rst_async_pg", {31'd0, PG}, 32'h0);
    chk("rst_async_gg", {31'd0, GG}, 32'h0);
`endif
    tick();
    chk("rst_hold_s", {28'd0, S}, 32'h0);
    chk("rst_hold_cout", {31'd0, Cout}, 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_s", {28'd0, S}, 32'hF);
    chk("post_rst_cout", {31'd0, Cout}, 32'h1);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      tick();
      chk($sformatf("vec%0d_s", i), {28'd0, S}, {28'd0, vecs[i].s});
      chk($sformatf("vec%0d_cout", i), {31'd0, Cout}, {31'd0, vecs[i].cout});
    end

    // Mid-stream reset discards the pending result
    drive(4'h8, 4'h9, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_s", {28'd0, S}, 32'h0);
    chk("mid_rst_cout", {31'd0, Cout}, 32'h0);
    tick();
    chk("mid_rst_hold_s", {28'd0, S}, 32'h0);
    rst = 1'b0;
    tick();
    chk("mid_rst_first_s", {28'd0, S}, 32'h1);
    chk("mid_rst_first_cout", {31'd0, Cout}, 32'h1);

    // 8-bit cascade: lower slice first, upper slice one cycle later with Cin = lower Cout
    drive(4'h4, 4'hD, 1'b0);
    tick();
    lo_s = S;
    lo_cout = Cout;
    drive(4'h8, 4'h0, lo_cout);
    tick();
    cas_exp = 9'h091;
    chk("cascade1", {23'd0, Cout, S, lo_s}, {23'd0, cas_exp});
    drive(4'h6, 4'hD, 1'b0);
    tick();
    lo_s = S;
    lo_cout = Cout;
    drive(4'hF, 4'h7, lo_cout);
    tick();
    cas_exp = 9'h173;
    chk("cascade2", {23'd0, Cout, S, lo_s}, {23'd0, cas_exp});

`ifdef CL_ADDER4_GROUP_PG_EN
    drive(4'h5, 4'hA, 1'b0);
    tick();
    chk("grp_pg_5a", {31'd0, PG}, 32'h1);
    chk("grp_gg_5a", {31'd0, GG}, 32'h0);
    drive(4'hF, 4'h1, 1'b0);
    tick();
    chk("grp_pg_f1", {31'd0, PG}, 32'h0);
    chk("grp_gg_f1", {31'd0, GG}, 32'h1);
`endif

    // Exhaustive sweep against the arithmetic sum
    for (int v = 0; v < 512; v++) begin
      drive(v[3:0], v[7:4], v[8]);
      model = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'd0, v[8]};
      tick();
      chk($sformatf("exh_%0d", v), {27'd0, Cout, S}, {27'd0, model});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
